bomberman_collision: RTL and testbench

Per-direction collision checker for the bomberman sprite. It continuously sweeps eight probe points one pixel outside the sprite's 16×16 bounding box. Each probe is looked up in the synchronous tile-map RAM, and the four blocked flags are compiled from the results. Output `bomberman_blocked` feeds the bomberman movement block directly.

---
 rtl/bomberman_pkg.sv | 59 +++++
 rtl/bomberman_collision_tile_addr_calc.sv | 40 ++++
 rtl/bomberman_collision.sv | 142 ++++++++++++++
 tb/tb_bomberman_collision.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared constants, types and probe geometry for the bomberman collision checker
package bomberman_pkg;

    localparam logic [1:0] TILE_EMPTY  = 2'b00;
    localparam logic [1:0] TILE_PILLAR = 2'b01;
    localparam logic [1:0] TILE_SOFT   = 2'b10;
    localparam logic [1:0] TILE_BOMB   = 2'b11;

    localparam int DIR_L  = 3;
    localparam int DIR_R  = 2;
    localparam int DIR_UP = 1;
    localparam int DIR_DN = 0;

    localparam int SPRITE_SIZE = 16;
    localparam int TILE_PX     = 16;

    localparam int DEF_ARENA_X0 = 144;
    localparam int DEF_ARENA_Y0 = 16;
    localparam int DEF_COLS     = 22;
    localparam int DEF_ROWS     = 25;
    localparam int DEF_ADDR_W   = 10;

    typedef enum logic [1:0] {
        ST_SNAP   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } sweep_state_e;

    typedef struct packed {
        logic signed [10:0] px;
        logic signed [10:0] py;
        logic [1:0]         dir;
    } probe_t;

    // Probe k of the sweep: two points per direction, each one pixel outside the box.
    // Signed 11-bit math keeps sx-1 at sx=0 negative so it lands out of bounds.
    function automatic probe_t probe_point(input logic [2:0] k,
                                           input logic [9:0] sx,
                                           input logic [9:0] sy);
        probe_t p;
        logic signed [10:0] x0;
        logic signed [10:0] y0;
        x0 = signed'({1'b0, sx});
        y0 = signed'({1'b0, sy});
        case (k)
            3'd0:    begin p.px = x0 - 11'sd1;  p.py = y0;          p.dir = 2'(DIR_L);  end
            3'd1:    begin p.px = x0 - 11'sd1;  p.py = y0 + 11'sd15; p.dir = 2'(DIR_L);  end
            3'd2:    begin p.px = x0 + 11'sd16; p.py = y0;          p.dir = 2'(DIR_R);  end
            3'd3:    begin p.px = x0 + 11'sd16; p.py = y0 + 11'sd15; p.dir = 2'(DIR_R);  end
            3'd4:    begin p.px = x0;           p.py = y0 + 11'sd16; p.dir = 2'(DIR_UP); end
            3'd5:    begin p.px = x0 + 11'sd15; p.py = y0 + 11'sd16; p.dir = 2'(DIR_UP); end
            3'd6:    begin p.px = x0;           p.py = y0 - 11'sd1;  p.dir = 2'(DIR_DN); end
            default: begin p.px = x0 + 11'sd15; p.py = y0 - 11'sd1;  p.dir = 2'(DIR_DN); end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bomberman_collision_tile_addr_calc.sv
// rtl/bomberman_collision_tile_addr_calc.sv - pixel probe to tile-map address with arena bounds check
module tile_addr_calc
    import bomberman_pkg::*;
#(
    parameter int ARENA_X0 = DEF_ARENA_X0,
    parameter int ARENA_Y0 = DEF_ARENA_Y0,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic signed [10:0] px,
    input  logic signed [10:0] py,
    output logic               oob,
    output logic [ADDR_W-1:0]  addr
);

    localparam logic signed [10:0] X_LO = 11'(ARENA_X0);
    localparam logic signed [10:0] Y_LO = 11'(ARENA_Y0);
    localparam logic signed [10:0] X_HI = 11'(ARENA_X0 + TILE_PX * COLS);
    localparam logic signed [10:0] Y_HI = 11'(ARENA_Y0 + TILE_PX * ROWS);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [6:0]         col;
    logic [6:0]         row;

    // Arena-relative offset, tile column/row, and a zero address for anything outside the arena.
    always_comb begin
        dx   = px - X_LO;
        dy   = py - Y_LO;
        col  = 7'(dx >> 4);
        row  = 7'(dy >> 4);
        oob  = (px < X_LO) || (px >= X_HI) || (py < Y_LO) || (py >= Y_HI);
        addr = '0;
        if (!oob) begin
            addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
        end
    end

endmodule

// File: rtl/bomberman_collision.sv
// rtl/bomberman_collision.sv - free-running eight-probe tile sweep producing per-direction blocked flags
module bomberman_collision
    import bomberman_pkg::*;
#(
    parameter int ARENA_X0 = DEF_ARENA_X0,
    parameter int ARENA_Y0 = DEF_ARENA_Y0,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        b_x,
    input  logic [9:0]        b_y,
    output logic              map_rd_en,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [1:0]        map_data,
    output logic [3:0]        bomberman_blocked,
    output logic              sweep_done
);

    sweep_state_e state_q, state_d;
    logic [2:0]   k_q, k_d;
    logic [9:0]   sx_q, sx_d;
    logic [9:0]   sy_q, sy_d;
    logic [3:0]   acc_q, acc_d;
    logic [3:0]   committed_q, committed_d;
    logic         pipe_vld_q, pipe_vld_d;
    logic         pipe_oob_q, pipe_oob_d;
    logic [1:0]   pipe_dir_q, pipe_dir_d;
    logic [3:0]   blocked_q, blocked_d;

    probe_t            probe;
    logic              probe_oob;
    logic [ADDR_W-1:0] probe_addr;
    logic              moved;

    // Current probe geometry is selected by the probe counter and fed to a single address calculator.
    always_comb begin
        probe = probe_point(k_q, sx_q, sy_q);
    end

    tile_addr_calc #(
        .ARENA_X0 (ARENA_X0),
        .ARENA_Y0 (ARENA_Y0),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .ADDR_W   (ADDR_W)
    ) u_addr (
        .px   (probe.px),
        .py   (probe.py),
        .oob  (probe_oob),
        .addr (probe_addr)
    );

    // State and datapath registers; committed starts all-blocked so nothing moves before the first sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SNAP;
            k_q         <= 3'd0;
            sx_q        <= 10'd0;
            sy_q        <= 10'd0;
            acc_q       <= 4'b0000;
            committed_q <= 4'b1111;
            pipe_vld_q  <= 1'b0;
            pipe_oob_q  <= 1'b0;
            pipe_dir_q  <= 2'd0;
            blocked_q   <= 4'b1111;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            acc_q       <= acc_d;
            committed_q <= committed_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_oob_q  <= pipe_oob_d;
            pipe_dir_q  <= pipe_dir_d;
            blocked_q   <= blocked_d;
        end
    end

    // Sweep sequencing: SNAP, eight ISSUE cycles, DRAIN for the last read, COMMIT, repeat.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_SNAP: begin
                state_d = ST_ISSUE;
                k_d     = 3'd0;
            end
            ST_ISSUE: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_SNAP;
            default:   state_d = ST_SNAP;
        endcase
    end

    // Snapshot, one-cycle read pipeline, accumulation, commit and the stale-position guard.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        acc_d       = acc_q;
        committed_d = committed_q;
        pipe_vld_d  = (state_q == ST_ISSUE);
        pipe_oob_d  = probe_oob;
        pipe_dir_d  = probe.dir;

        if (state_q == ST_SNAP) begin
            sx_d  = b_x;
            sy_d  = b_y;
            acc_d = 4'b0000;
        end

        // Out-of-bounds probes never read the map, so stale map_data is masked by the oob flag.
        if (pipe_vld_q) begin
            acc_d[pipe_dir_q] = acc_q[pipe_dir_q] | pipe_oob_q | (map_data != TILE_EMPTY);
        end

        if (state_q == ST_COMMIT) begin
            committed_d = acc_q;
        end

        // Any difference from the snapshot blocks every direction, even on the commit edge itself.
        moved     = ({b_x, b_y} != {sx_q, sy_q});
        blocked_d = committed_d | {4{moved}};
    end

    // Map read strobe/address during ISSUE, commit pulse, registered blocked flags.
    always_comb begin
        map_rd_en         = (state_q == ST_ISSUE) && !probe_oob;
        map_addr          = map_rd_en ? probe_addr : '0;
        sweep_done        = (state_q == ST_COMMIT);
        bomberman_blocked = blocked_q;
    end

endmodule

// File: tb/tb_bomberman_collision.sv
// tb/tb_bomberman_collision.sv - directed self-checking bench for bomberman_collision
module tb_bomberman_collision;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] b_x = 10'd144;
    logic [9:0] b_y = 10'd400;
    logic       map_rd_en;
    logic [9:0] map_addr;
    logic [1:0] map_data = 2'b00;
    logic [3:0] bomberman_blocked;
    logic       sweep_done;

    logic [1:0] mem [0:549];
    int         checks = 0;
    int         failures = 0;
    int         cnt = 0;
    logic [7:0] cur_mask = 8'h00;
    logic [7:0] last_mask = 8'h00;
    int         max_addr = 0;
    logic [3:0] blk;

    bomberman_collision dut (
        .clk               (clk),
        .reset             (reset),
        .b_x               (b_x),
        .b_y               (b_y),
        .map_rd_en         (map_rd_en),
        .map_addr          (map_addr),
        .map_data          (map_data),
        .bomberman_blocked (bomberman_blocked),
        .sweep_done        (sweep_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (map_rd_en) map_data <= mem[map_addr];
    end

    always @(negedge clk) begin
        if (map_rd_en && int'(map_addr) > max_addr) max_addr <= int'(map_addr);
        if (sweep_done) begin
            cnt       <= 0;
            last_mask <= cur_mask;
            cur_mask  <= 8'h00;
        end else begin
            cnt <= cnt + 1;
            if (map_rd_en && map_addr == 10'd24 && cnt >= 1 && cnt <= 8) cur_mask[cnt-1] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < 550; i++) mem[i] = 2'b00;
    endtask

    task automatic sweep(output logic [3:0] res);
        int n;
        n = 0;
        while (sweep_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sweep_done !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL sweep_timeout observed=0 expected=1");
        end
        @(negedge clk);
        res = bomberman_blocked;
    endtask

    initial begin
        clear_map();
        repeat (3) @(negedge clk);
        chk("rst_blocked", 32'(bomberman_blocked), 32'hF);
        chk("rst_done",    32'(sweep_done),        32'h0);
        chk("rst_rd_en",   32'(map_rd_en),         32'h0);
        chk("rst_addr",    32'(map_addr),          32'h0);

        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("c11_blocked", 32'(bomberman_blocked), 32'hF);
        chk("c11_done",    32'(sweep_done),        32'h1);
        @(negedge clk);
        chk("c12_blocked", 32'(bomberman_blocked), 32'hA);
        chk("c12_done",    32'(sweep_done),        32'h0);
        repeat (10) @(negedge clk);
        chk("c22_done",    32'(sweep_done),        32'h1);
        chk("c22_blocked", 32'(bomberman_blocked), 32'hA);

        b_x = 10'd160; b_y = 10'd32;
        @(negedge clk);
        chk("move_guard", 32'(bomberman_blocked), 32'hF);
        sweep(blk);
        sweep(blk);
        chk("empty_160_32", 32'(blk), 32'h0);

        mem[24] = 2'b01;
        sweep(blk);
        sweep(blk);
        chk("pillar_24", 32'(blk), 32'h4);
        chk("pillar_k_mask", 32'(last_mask), 32'h0C);

        mem[24] = 2'b11;
        sweep(blk);
        chk("bomb_24", 32'(blk), 32'h4);

        clear_map();
        mem[0] = 2'b10;
        b_x = 10'd144; b_y = 10'd32;
        sweep(blk);
        sweep(blk);
        chk("soft_0", 32'(blk), 32'h9);

        sweep(blk);
        repeat (5) @(negedge clk);
        chk("k4_rd_en", 32'(map_rd_en), 32'h1);
        chk("k4_addr",  32'(map_addr),  32'd44);
        reset = 1'b1;
        #1;
        chk("mid_rst_blocked", 32'(bomberman_blocked), 32'hF);
        chk("mid_rst_done",    32'(sweep_done),        32'h0);
        chk("mid_rst_rd_en",   32'(map_rd_en),         32'h0);
        chk("mid_rst_addr",    32'(map_addr),          32'h0);
        b_x = 10'd160; b_y = 10'd32;
        mem[0] = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_c11", 32'(bomberman_blocked), 32'hF);
        chk("post_rst_done", 32'(sweep_done), 32'h1);
        @(negedge clk);
        chk("post_rst_c12", 32'(bomberman_blocked), 32'h0);

        mem[23] = 2'b10;
        sweep(blk);
        sweep(blk);
        chk("pre_move", 32'(blk), 32'h0);
        sweep(blk);
        repeat (3) @(negedge clk);
        b_x = 10'd161;
        @(negedge clk);
        chk("mid_move_guard", 32'(bomberman_blocked), 32'hF);
        sweep(blk);
        chk("stale_commit", 32'(blk), 32'hF);
        sweep(blk);
        chk("moved_161", 32'(blk), 32'h8);

        chk("max_addr_in_map", 32'(max_addr <= 549), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
